// File: rtl/mux8_rr_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_sched_pkg
// Description : Shared constants, state encoding and helpers for the 8:1 mux
//               round-robin scheduler (mux8_rr_sched) and its picker
//               (rr_pick8).
//               Contents:
//                 N_REQ   - number of requesters (8)
//                 SEL_W   - mux select width (3)
//                 state_t - scheduler state encoding (IDLE / GRANT)
//                 onehot8 - 3-bit index to 8-bit one-hot conversion
// Revision    : 1.0 - initial release
// ============================================================================
package mux_sched_pkg;

  localparam int N_REQ = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic logic [N_REQ-1:0] onehot8(input logic [SEL_W-1:0] idx);
    return {{(N_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage : mux_sched_pkg
`default_nettype wire

// File: rtl/mux8_rr_sched_rr_pick8.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick8
// Description : Combinational rotating-priority picker over 8 requests.
//               Candidates are i_req with the i_mask bits removed.  The search
//               starts at i_ptr and walks upward modulo 8; the first candidate
//               found wins.
// Ports       : i_req   [7:0] in  - request vector
//               i_mask  [7:0] in  - requests to exclude from this pick
//               i_ptr   [2:0] in  - highest-priority index
//               o_found       out - at least one candidate exists
//               o_idx   [2:0] out - winning index (0 when none found)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick8
  import mux_sched_pkg::*;
(
  input  logic [N_REQ-1:0] i_req,
  input  logic [N_REQ-1:0] i_mask,
  input  logic [SEL_W-1:0] i_ptr,
  output logic             o_found,
  output logic [SEL_W-1:0] o_idx
);

  logic [N_REQ-1:0] w_cand;
  logic [SEL_W-1:0] w_pos;

  assign w_cand = i_req & ~i_mask;

  // Scan from the farthest position back towards i_ptr so that the last
  // hit written is the nearest one; the 3-bit add supplies the 7->0 wrap.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    w_pos   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_pos = i_ptr + SEL_W'(k);
      if (w_cand[w_pos]) begin
        o_found = 1'b1;
        o_idx   = w_pos;
      end
    end
  end

endmodule : rr_pick8
`default_nettype wire

// File: rtl/mux8_rr_sched.sv
`default_nettype none
// ============================================================================
// Module      : mux8_rr_sched
// Description : Round-robin scheduler owning the select of a shared 8:1
//               single-bit mux.  One owner at a time; on release the next
//               winner is granted on the following edge with no idle bubble.
//               Optional feature macro: MUX8_SCHED_HOLD_TIMEOUT_EN
//                 defined   - owner force-released after MAX_HOLD grant cycles
//                 undefined - only i_done or a dropped request releases
// Ports       : clk           in  - rising-edge clock
//               rst_n         in  - asynchronous active-low reset
//               i_req   [7:0] in  - request vector, bit i = requester i
//               i_done        in  - owner's last cycle (used in GRANT only)
//               o_sel   [2:0] out - mux select (holds last value when idle)
//               o_gnt   [7:0] out - one-hot grant, zero when no owner
//               o_busy        out - an owner holds the mux
// Revision    : 1.0 - initial release
// ============================================================================
module mux8_rr_sched
  import mux_sched_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] i_req,
  input  logic             i_done,
  output logic [SEL_W-1:0] o_sel,
  output logic [N_REQ-1:0] o_gnt,
  output logic             o_busy
);

  state_t           r_state;
  logic [SEL_W-1:0] r_ptr;
  logic [SEL_W-1:0] r_sel;
  logic [N_REQ-1:0] r_gnt;
  logic             r_busy;

  logic             w_in_grant;
  logic [N_REQ-1:0] w_pick_mask;
  logic [SEL_W-1:0] w_pick_ptr;
  logic             w_timeout;
  logic             w_release;
  logic             w_found;
  logic [SEL_W-1:0] w_idx;

`ifdef MUX8_SCHED_HOLD_TIMEOUT_EN
  logic [3:0]       r_hold_cnt;

  assign w_timeout = (r_hold_cnt == 4'(MAX_HOLD));
`else
  logic [3:0]       w_unused_max_hold;

  assign w_unused_max_hold = 4'(MAX_HOLD);
  assign w_timeout         = 1'b0;
`endif

  assign w_in_grant = (r_state == GRANT);
  assign w_release  = w_in_grant & (i_done | ~i_req[r_sel] | w_timeout);

  // One picker serves both arbitration points.  In GRANT the current owner
  // is masked and the search starts just past it, which is exactly the
  // pointer value committed on release; in IDLE nothing is masked.
  assign w_pick_mask = w_in_grant ? onehot8(r_sel) : '0;
  assign w_pick_ptr  = w_in_grant ? (r_sel + SEL_W'(1)) : r_ptr;

  rr_pick8 u_pick (
    .i_req   (i_req),
    .i_mask  (w_pick_mask),
    .i_ptr   (w_pick_ptr),
    .o_found (w_found),
    .o_idx   (w_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_sel      <= '0;
      r_gnt      <= '0;
      r_busy     <= 1'b0;
`ifdef MUX8_SCHED_HOLD_TIMEOUT_EN
      r_hold_cnt <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_state    <= GRANT;
            r_sel      <= w_idx;
            r_gnt      <= onehot8(w_idx);
            r_busy     <= 1'b1;
`ifdef MUX8_SCHED_HOLD_TIMEOUT_EN
            r_hold_cnt <= 4'd1;
`endif
          end
        end
        GRANT: begin
          if (w_release) begin
            r_ptr <= w_pick_ptr;
            if (w_found) begin
              // Back-to-back handover: busy stays high.
              r_sel      <= w_idx;
              r_gnt      <= onehot8(w_idx);
`ifdef MUX8_SCHED_HOLD_TIMEOUT_EN
              r_hold_cnt <= 4'd1;
`endif
            end else begin
              // r_sel deliberately keeps the last owner.
              r_state <= IDLE;
              r_gnt   <= '0;
              r_busy  <= 1'b0;
            end
          end
`ifdef MUX8_SCHED_HOLD_TIMEOUT_EN
          else if (r_hold_cnt != 4'hF) begin
            r_hold_cnt <= r_hold_cnt + 4'd1;
          end
`endif
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_sel  = r_sel;
  assign o_gnt  = r_gnt;
  assign o_busy = r_busy;

endmodule : mux8_rr_sched
`default_nettype wire

// File: tb/tb_mux8_rr_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux8_rr_sched
// Description : Self-checking bench for mux8_rr_sched.  A behavioural model
//               tracks owner / priority pointer / hold count as integers and
//               predicts gnt, busy and sel after every edge.  Directed steps
//               cover reset, single request, rotation, wrap/skip, timeout,
//               mux data path and reset during grant, followed by random
//               traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux8_rr_sched;

  localparam int MAX_HOLD = 4;
`ifdef MUX8_SCHED_HOLD_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [7:0] i_req;
  logic       i_done;
  logic [2:0] o_sel;
  logic [7:0] o_gnt;
  logic       o_busy;

  int checks   = 0;
  int failures = 0;

  // Model state
  int m_owner;  // -1 when no owner
  int m_ptr;
  int m_hold;
  int m_sel;

  mux8_rr_sched #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_req  (i_req),
    .i_done (i_done),
    .o_sel  (o_sel),
    .o_gnt  (o_gnt),
    .o_busy (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int pick(input logic [7:0] r, input int p);
    for (int k = 0; k < 8; k++) begin
      if (r[(p + k) % 8]) return (p + k) % 8;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_hold  = 0;
    m_sel   = 0;
  endtask

  task automatic model_step(input logic [7:0] r, input logic d);
    int w;
    logic [7:0] rm;
    if (m_owner < 0) begin
      w = pick(r, m_ptr);
      if (w >= 0) begin
        m_owner = w; m_sel = w; m_hold = 1;
      end
    end else if (d || !r[m_owner] || (TO_EN && m_hold == MAX_HOLD)) begin
      m_ptr = (m_owner + 1) % 8;
      rm = r;
      rm[m_owner] = 1'b0;
      w = pick(rm, m_ptr);
      if (w >= 0) begin
        m_owner = w; m_sel = w; m_hold = 1;
      end else begin
        m_owner = -1;
      end
    end else if (m_hold < 15) begin
      m_hold++;
    end
  endtask

  task automatic check(input string tag);
    logic [7:0] one;
    logic [7:0] exp_gnt;
    logic       exp_busy;
    logic [2:0] exp_sel;
    one      = 8'h01;
    exp_gnt  = (m_owner >= 0) ? (one << m_owner) : 8'h00;
    exp_busy = (m_owner >= 0);
    exp_sel  = 3'(m_sel);
    checks++;
    assert (o_gnt === exp_gnt) else begin
      failures++;
      $error("FAIL %s gnt: observed=%h expected=%h", tag, o_gnt, exp_gnt);
    end
    checks++;
    assert (o_busy === exp_busy) else begin
      failures++;
      $error("FAIL %s busy: observed=%b expected=%b", tag, o_busy, exp_busy);
    end
    checks++;
    assert (o_sel === exp_sel) else begin
      failures++;
      $error("FAIL %s sel: observed=%0d expected=%0d", tag, o_sel, exp_sel);
    end
  endtask

  // Drive inputs away from the edge, advance the model, clock, then check.
  task automatic cycle(input logic [7:0] r, input logic d, input string tag);
    i_req  = r;
    i_done = d;
    model_step(r, d);
    @(posedge clk);
    #1;
    check(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #2;
    check("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  logic [7:0] mux_data;
  logic [7:0] mux_exp;
  logic       mux_out;
  logic [7:0] rr;

  initial begin
    rst_n    = 1'b0;
    i_req    = 8'h00;
    i_done   = 1'b0;
    mux_data = 8'b1010_0110;
    mux_exp  = 8'b1010_0110;
    model_reset();

    // Reset state
    #3;
    check("reset_init");
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // done in IDLE is ignored
    cycle(8'h00, 1'b1, "idle_done");

    // Single request
    cycle(8'h08, 1'b0, "single_gnt");
    cycle(8'h00, 1'b1, "single_rel");
    cycle(8'h00, 1'b0, "single_idle");

    // Rotation with done pulsed on every grant
    do_reset();
    for (int i = 0; i < 10; i++) cycle(8'hFF, 1'b1, "rotate");

    // Wrap/skip: grant 5, release -> ptr 6, then req 05 and 41
    do_reset();
    cycle(8'h20, 1'b0, "wrap_g5");
    cycle(8'h05, 1'b1, "wrap_g0");
    cycle(8'h05, 1'b1, "wrap_g2");
    cycle(8'h41, 1'b0, "wrap_g6");
    cycle(8'h41, 1'b1, "wrap_skip6");

    // Timeout (or indefinite hold without the feature)
    do_reset();
    for (int i = 0; i < 13; i++) cycle(8'h03, 1'b0, "hold");

    // Mux path: walk owners 0..7 back to back
    do_reset();
    for (int w = 0; w < 8; w++) begin
      rr = 8'h01 << w;
      cycle(rr, 1'b0, "mux_walk");
      mux_out = mux_data[o_sel];
      checks++;
      assert (mux_out === mux_exp[w]) else begin
        failures++;
        $error("FAIL mux_out[%0d]: observed=%b expected=%b", w, mux_out, mux_exp[w]);
      end
    end

    // Reset asserted mid-grant clears outputs without a clock edge
    do_reset();
    cycle(8'h20, 1'b0, "pre_rst_g5");
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    cycle(8'h01, 1'b0, "post_rst_g0");

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rr = 8'($urandom);
      if ($urandom_range(0, 2) == 0) rr = rr & 8'($urandom);
      cycle(rr, 1'($urandom_range(0, 3) == 0), "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_mux8_rr_sched
`default_nettype wire

// File: doc/mux8_rr_sched.md
Name: mux8_rr_sched

Overview:
- Round-robin scheduler that shares one 8:1 single-bit mux datapath among 8 requesters.
- Owns the mux's 3-bit select: each requester drives one mux data input, and the scheduler steers the winner's input to the mux output.
- Sits between the requester logic and the 8:1 mux instance; the mux itself is untouched.

Parameters:
- N_REQ, 8, number of requesters; fixed at 8 to match the mux width.
- SEL_W, 3, select width; equals log2(N_REQ).
- MAX_HOLD, 4, maximum consecutive grant cycles per owner (timeout feature only); legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  8  request vector; bit i = requester i wants the mux.
- done  input  1  owner's last cycle; sampled only in GRANT.
- sel  output  3  mux select; drives the mux select bits, LSB = first mux stage.
- gnt  output  8  one-hot grant; all zero when no owner.
- busy  output  1  high while an owner holds the mux.

Behaviour:
- All outputs are registered. Reset (async, rst_n=0) forces:
  - sel=0, gnt=0, busy=0, state=IDLE.
  - ptr=0 (next-priority index), hold_cnt=0.
- Reset may assert mid-grant: outputs clear immediately, with no completion cycle.
- States: IDLE, GRANT.
- IDLE:
  - if req==0, stay.
  - else winner = first set bit scanning ptr, ptr+1, ..., ptr+7 (mod 8).
  - next edge: state=GRANT, sel=winner, gnt=1<<winner, busy=1, hold_cnt=1.
  - Latency req->gnt = 1 cycle.
- GRANT, owner o=sel. Release condition (evaluated each cycle):
  - done=1, or
  - req[o]=0, or
  - (timeout feature only) hold_cnt==MAX_HOLD.
- On release:
  - ptr <= (o+1) mod 8.
  - Re-arbitrate in the same cycle over req with bit o masked and the new ptr.
  - If another requester wins, the next edge grants it directly: no IDLE bubble, busy stays 1, hold_cnt=1.
  - If no other request, go to IDLE: gnt=0, busy=0. sel holds its last value (don't-care).
- No release: stay in GRANT, hold_cnt saturating increment (4-bit).
- Simultaneous requests: resolved strictly by rotating priority from ptr. Index wrap 7->0 is mod-8 arithmetic on 3 bits.
- A requester that is re-requesting after its own release is skipped for that arbitration. It may win the following one if it is the only request.
- done while in IDLE: ignored.
- req bits may change at any time. Only req[o] matters during GRANT.
- Invariants:
  - gnt is always one-hot or zero.
  - gnt[sel]==busy.

Optional Feature:
- Macro: MUX8_SCHED_HOLD_TIMEOUT_EN.
- Defined: grant is force-released when hold_cnt reaches MAX_HOLD, i.e. after exactly MAX_HOLD grant cycles, even with req[o]=1 and done=0.
- Undefined:
  - No timeout; only done or a dropped req releases.
  - hold_cnt logic is removed.
  - MAX_HOLD is ignored.

Decomposition:
- Shared package mux_sched_pkg holds:
  - constants N_REQ=8, SEL_W=3.
  - state encoding IDLE=1'b0, GRANT=1'b1.
  - function onehot8(idx) returning the 8-bit one-hot.
- One combinational sub-module, rr_pick8: inputs req[7:0], mask[7:0], ptr[2:0]; outputs found, idx[2:0]. It is reused for both IDLE and release re-arbitration.
- FSM, ptr and hold_cnt live in the top module.

Test Plan:
- Reset during grant: owner 5 active, pull rst_n low mid-cycle -> gnt=0, busy=0, sel=0 immediately, asynchronously; after release, req=8'h01 -> gnt=8'h01 one cycle later.
- Single request: req=8'h08 from IDLE -> next edge sel=3, gnt=8'h08, busy=1; done=1 for one cycle with req=0 after -> IDLE, gnt=0, busy=0.
- Rotation: req=8'hFF held, done pulsed every grant -> sel sequence 0,1,2,...,7,0 with no idle cycles; busy stays 1.
- Wrap/skip: ptr=6, req=8'h05 -> sel=0 first, then sel=2; with req=8'h41 after owner 6 releases -> sel=0, not 6.
- Timeout, macro defined: MAX_HOLD=4, req=8'h03 held, done=0 -> gnt=8'h01 for exactly 4 cycles, then 8'h02 for 4 cycles, alternating. Macro undefined -> gnt=8'h01 held indefinitely.
- Mux path: connect to the 8:1 mux with data = 8'b1010_0110, walk winners 0..7 -> mux output = data[sel] each cycle: 0,1,1,0,0,1,0,1.
